noc_vc_mux_arbiter: RTL
=======================

NOC_VC_MUX_ARBITER -- requirements
Module: noc_vc_mux_arbiter

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2, meaning the number of virtual channels merged (legal range 1..8).
REQ-002 The block SHALL have parameter FLIT_WIDTH, default 64, meaning the flit payload width in bits.
REQ-003 The block SHALL have derived localparam VC_WIDTH = max(1, clog2(CHANNELS)), meaning the width of the channel index.
REQ-004 clk  input  1  the single clock; all state is rising-edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 i_vc_valid  input  CHANNELS  per-channel flit valid from the per-VC input FIFOs.
REQ-007 o_vc_ready  output  CHANNELS  per-channel pop/accept.
REQ-008 i_vc_flit  input  CHANNELS*FLIT_WIDTH  per-channel payload; channel i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
REQ-009 i_vc_head  input  CHANNELS  per-channel head-flit marker.
REQ-010 i_vc_tail  input  CHANNELS  per-channel tail-flit marker.
REQ-011 o_valid  output  1  merged link flit valid.
REQ-012 i_ready  input  1  downstream accept.
REQ-013 o_flit  output  FLIT_WIDTH  merged payload.
REQ-014 o_head / o_tail  output  1 each  head/tail markers of o_flit.
REQ-015 o_vc  output  VC_WIDTH  index of the source channel of o_flit.

Function
REQ-016 The block SHALL register the output: o_valid, o_flit, o_head, o_tail and o_vc are flops; latency from input accept to o_valid is exactly 1 cycle.
REQ-017 The load enable SHALL be load = !o_valid | i_ready; full throughput of one flit per cycle while i_ready=1.
REQ-018 o_vc_ready[i] SHALL be load & grant[i]; at most one bit of o_vc_ready is set in any cycle; o_vc_ready is never asserted for a channel with i_vc_valid=0.
REQ-019 Arbiter states SHALL be IDLE (unlocked) and LOCKED(ch).
REQ-020 In IDLE the grant SHALL go to the first channel with i_vc_valid=1, searching upward from rr_ptr with wrap-around from CHANNELS-1 to 0.
REQ-021 In LOCKED(ch) only channel ch SHALL be eligible; other valid channels wait irrespective of i_vc_valid[ch].
REQ-022 Accepting a flit with head=1, tail=0 in IDLE SHALL transition to LOCKED(granted channel).
REQ-023 Accepting a flit with tail=1 SHALL transition to IDLE; a single-flit packet (head=1, tail=1) never locks.
REQ-024 rr_ptr SHALL update to (granted+1) mod CHANNELS on every accepted head flit and hold otherwise.
REQ-025 A non-head flit accepted in IDLE SHALL be forwarded unchanged, with no state change.
REQ-026 When o_valid=1 and i_ready=0, all outputs SHALL hold stable and o_vc_ready SHALL be 0.
REQ-027 For CHANNELS=1 the block SHALL degenerate to a 1-deep register slice, with o_vc = 0.

Reset
REQ-028 On rst=1 the block SHALL asynchronously clear o_valid, o_flit, o_head, o_tail, o_vc and rr_ptr to 0 and the state to IDLE.
REQ-029 Reset asserted mid-packet SHALL discard the registered flit and unlock; after release, arbitration restarts from channel 0.

Configuration
REQ-030 With macro NOC_VC_MUX_ARBITER_CLEAR_EN defined, the block SHALL add input i_clear (1 bit, synchronous); i_clear=1 SHALL clear o_valid, force IDLE and reset rr_ptr to 0 on the next edge, and force o_vc_ready to 0 in that cycle.
REQ-031 Without NOC_VC_MUX_ARBITER_CLEAR_EN, the i_clear port SHALL NOT exist and the behaviour is as in REQ-016..029.

Verification
REQ-032 CHANNELS=2, both valid with single-flit packets, i_ready=1 held -> o_vc sequence 0,1,0,1 on consecutive cycles; o_valid first rises 1 cycle after the first accept.
REQ-033 ch0 sends a 3-flit packet (H, -, T) while ch1 is valid throughout -> all three ch0 flits appear back-to-back before any ch1 flit; o_vc_ready[1]=0 during the lock.
REQ-034 o_valid=1 with i_ready=0 for 4 cycles -> o_flit/o_vc stable and o_vc_ready=0 for all 4 cycles; the next flit appears in the cycle after i_ready returns to 1.
REQ-035 rst pulsed after the head flit of a 2-flit packet on ch1 -> o_valid=0 immediately; after release, ch0 (valid) wins over ch1.
REQ-036 CHANNELS=4, only ch3 valid, then ch3 and ch0 valid -> ch3 granted first, then ch0 (rr_ptr wraps 3->0).
REQ-037 NOC_VC_MUX_ARBITER_CLEAR_EN defined, i_clear=1 while LOCKED(1) -> next cycle o_valid=0, state IDLE, ch0 granted if valid.

Source files
------------

// File: rtl/noc_vc_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : noc_vc_mux_arbiter
//  Description : Merges CHANNELS virtual-channel flit streams onto one link.
//                Round-robin arbitration between packets, with wormhole
//                locking from head to tail. The output stage is a registered
//                slice.
//                Optional macro NOC_VC_MUX_ARBITER_CLEAR_EN adds a synchronous
//                i_clear input that flushes the slice and the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_vc_mux_arbiter #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 64,
  localparam int VC_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef NOC_VC_MUX_ARBITER_CLEAR_EN
  input  logic                           i_clear,
`endif
  input  logic [CHANNELS-1:0]            i_vc_valid,
  output logic [CHANNELS-1:0]            o_vc_ready,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] i_vc_flit,
  input  logic [CHANNELS-1:0]            i_vc_head,
  input  logic [CHANNELS-1:0]            i_vc_tail,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [FLIT_WIDTH-1:0]          o_flit,
  output logic                           o_head,
  output logic                           o_tail,
  output logic [VC_WIDTH-1:0]            o_vc
);

  localparam logic [VC_WIDTH-1:0] c_last_ch = VC_WIDTH'(CHANNELS - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [VC_WIDTH-1:0]   r_lock_ch, w_lock_ch_nxt;
  logic [VC_WIDTH-1:0]   r_rr_ptr, w_rr_ptr_nxt;

  logic                  r_valid;
  logic [FLIT_WIDTH-1:0] r_flit;
  logic                  r_head;
  logic                  r_tail;
  logic [VC_WIDTH-1:0]   r_vc;

  logic [VC_WIDTH-1:0]   w_cand [CHANNELS];
  logic [CHANNELS-1:0]   w_grant;
  logic [VC_WIDTH-1:0]   w_gnt_idx;
  logic                  w_gnt_any;
  logic                  w_clear;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_sel_head;
  logic                  w_sel_tail;

`ifdef NOC_VC_MUX_ARBITER_CLEAR_EN
  assign w_clear = i_clear;
`else
  assign w_clear = 1'b0;
`endif

  // The slice can take a new flit whenever it is empty or being drained.
  assign w_load     = (!r_valid || i_ready) && !w_clear;
  assign w_accept   = w_load && w_gnt_any;
  assign o_vc_ready = w_load ? w_grant : '0;
  assign w_sel_head = i_vc_head[w_gnt_idx];
  assign w_sel_tail = i_vc_tail[w_gnt_idx];

  assign o_valid = r_valid;
  assign o_flit  = r_flit;
  assign o_head  = r_head;
  assign o_tail  = r_tail;
  assign o_vc    = r_vc;

  // Round-robin search order: channels starting at rr_ptr, wrapping to 0.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(r_rr_ptr) + k >= CHANNELS)
        w_cand[k] = VC_WIDTH'(int'(r_rr_ptr) + k - CHANNELS);
      else
        w_cand[k] = VC_WIDTH'(int'(r_rr_ptr) + k);
    end
  end

  // Grant selection: locked channel only, or first valid in search order.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    if (r_state == ST_LOCKED) begin
      if (i_vc_valid[r_lock_ch]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = r_lock_ch;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (!w_gnt_any && i_vc_valid[w_cand[k]]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = w_cand[k];
        end
      end
    end
    if (w_gnt_any)
      w_grant[w_gnt_idx] = 1'b1;
  end

  // Next-state logic: heads advance the pointer, tails unlock, multi-flit heads lock.
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_ch_nxt = r_lock_ch;
    w_rr_ptr_nxt  = r_rr_ptr;
    if (w_clear) begin
      w_state_nxt  = ST_IDLE;
      w_rr_ptr_nxt = '0;
    end else if (w_accept) begin
      if (w_sel_head)
        w_rr_ptr_nxt = (w_gnt_idx == c_last_ch) ? '0 : w_gnt_idx + 1'b1;
      if (w_sel_tail) begin
        w_state_nxt = ST_IDLE;
      end else if (r_state == ST_IDLE && w_sel_head) begin
        w_state_nxt   = ST_LOCKED;
        w_lock_ch_nxt = w_gnt_idx;
      end
    end
  end

  // Arbiter state and output slice registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lock_ch <= '0;
      r_rr_ptr  <= '0;
      r_valid   <= 1'b0;
      r_flit    <= '0;
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_vc      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_ch_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      if (w_clear) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= w_gnt_any;
        if (w_gnt_any) begin
          r_flit <= i_vc_flit[int'(w_gnt_idx)*FLIT_WIDTH +: FLIT_WIDTH];
          r_head <= w_sel_head;
          r_tail <= w_sel_tail;
          r_vc   <= w_gnt_idx;
        end
      end
    end
  end

endmodule
`default_nettype wire
